friscv_regfile_sb: RTL and testbench

//  Parametrised ISA register file with integrated scoreboard for the next-gen friscv core.
//  - NRD combinational read ports; NWR byte-strobed write ports (control, ALU, memfy, ...).
//  - One issue port marks a destination register pending until a write port retires it.
//  - Optional same-cycle write-to-read bypass; RV32E mode (16 registers).

---
 rtl/friscv_regfile_sb_pkg.sv | 27 ++
 rtl/friscv_regfile_sb_wrmerge.sv | 47 ++++
 rtl/friscv_regfile_sb.sv | 154 +++++++++++++++
 tb/tb_friscv_regfile_sb.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/friscv_regfile_sb_pkg.sv
// Shared definitions for the friscv register file with integrated scoreboard.
package friscv_regfile_sb_pkg;

    localparam int REG_ADDRW  = 5;
    localparam int RV32I_NREG = 32;
    localparam int RV32E_NREG = 16;
    localparam int CNT_W      = 6;

    typedef logic [REG_ADDRW-1:0] reg_addr_t;
    typedef logic [CNT_W-1:0]     pend_cnt_t;

    // True when the address names an implemented architectural register.
    function automatic logic addr_in_range(input reg_addr_t addr, input int nreg);
        return int'(addr) < nreg;
    endfunction

    // Number of set bits in a scoreboard vector (zero-extended to RV32I size).
    function automatic pend_cnt_t popcount(input logic [RV32I_NREG-1:0] bits);
        pend_cnt_t cnt;
        cnt = '0;
        for (int i = 0; i < RV32I_NREG; i++) begin
            cnt = cnt + pend_cnt_t'(bits[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/friscv_regfile_sb_wrmerge.sv
// Per-register write merge: folds all write ports into the next register value
// lane by lane, highest port index winning, and flags lanes hit more than once.
// Also used combinationally as the read bypass value.
module friscv_regfile_sb_wrmerge #(
    parameter int XLEN = 32,
    parameter int NWR  = 3
) (
    input  logic [NWR-1:0]        wr_en_i,
    input  logic [NWR-1:0]        addr_hit_i,
    input  logic [NWR*XLEN/8-1:0] wr_strb_i,
    input  logic [NWR*XLEN-1:0]   wr_val_i,
    input  logic [XLEN-1:0]       cur_val_i,
    output logic [XLEN-1:0]       nxt_val_o,
    output logic                  any_write_o,
    output logic                  collision_o
);

    localparam int NLANE = XLEN / 8;

    logic [NWR-1:0]   sel;
    logic [NLANE-1:0] lane_taken;

    // Any enabled port aimed at this register counts, even with an all-zero strobe.
    assign sel         = wr_en_i & addr_hit_i;
    assign any_write_o = |sel;

    // Walk ports low to high so the highest-index port owns every lane it strobes.
    always_comb begin
        // NOTE: every output gets a default before the loops, so no path can leave
        // one unassigned and infer a latch; blocking '=' lets later ports override.
        nxt_val_o   = cur_val_i;
        lane_taken  = '0;
        collision_o = 1'b0;
        for (int p = 0; p < NWR; p++) begin
            for (int l = 0; l < NLANE; l++) begin
                if (sel[p] && wr_strb_i[p*NLANE + l]) begin
                    if (lane_taken[l]) begin
                        collision_o = 1'b1;
                    end
                    lane_taken[l]        = 1'b1;
                    nxt_val_o[l*8 +: 8] = wr_val_i[p*XLEN + l*8 +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/friscv_regfile_sb.sv
// ISA register file with byte-strobed write ports, combinational read ports,
// optional write-to-read bypass and a one-bit-per-register pending scoreboard.
module friscv_regfile_sb
    import friscv_regfile_sb_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int NRD    = 4,
    parameter int NWR    = 3,
    parameter int BYPASS = 1
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic                     srst,
    input  logic [NRD*REG_ADDRW-1:0] rd_addr,
    output logic [NRD*XLEN-1:0]      rd_val,
    output logic [NRD-1:0]           rd_busy,
    input  logic [NWR-1:0]           wr_en,
    input  logic [NWR*REG_ADDRW-1:0] wr_addr,
    input  logic [NWR*XLEN-1:0]      wr_val,
    input  logic [NWR*XLEN/8-1:0]    wr_strb,
    input  logic                     iss_valid,
    input  logic [REG_ADDRW-1:0]     iss_addr,
    output logic                     iss_ready,
    output logic [CNT_W-1:0]         pending_cnt,
    output logic                     wr_collision,
    output logic                     addr_err
);

    logic [XLEN-1:0] reg_val [NREG];   // stored value, x0 tied to zero
    logic [XLEN-1:0] mrg_val [NREG];   // stored value merged with this cycle's writes
    logic [NREG-1:0] reg_wr;           // some enabled port targets the register
    logic [NREG-1:0] reg_coll;         // two ports hit the same lane of the register

    logic [NREG-1:0] sb_q, sb_d, sb_set, busy_now;
    pend_cnt_t       cnt_q;
    logic            coll_q;
    logic            err_q, err_d;

    for (genvar r = 0; r < NREG; r++) begin : g_reg
        if (r == 0) begin : g_zero
            assign reg_val[r]  = '0;
            assign mrg_val[r]  = '0;
            assign reg_wr[r]   = 1'b0;
            assign reg_coll[r] = 1'b0;
        end else begin : g_arch
            logic [NWR-1:0]  hit;
            logic [XLEN-1:0] val_q;

            for (genvar p = 0; p < NWR; p++) begin : g_hit
                assign hit[p] = (wr_addr[p*REG_ADDRW +: REG_ADDRW] == REG_ADDRW'(r));
            end

            friscv_regfile_sb_wrmerge #(
                .XLEN (XLEN),
                .NWR  (NWR)
            ) u_wrmerge (
                .wr_en_i     (wr_en),
                .addr_hit_i  (hit),
                .wr_strb_i   (wr_strb),
                .wr_val_i    (wr_val),
                .cur_val_i   (val_q),
                .nxt_val_o   (mrg_val[r]),
                .any_write_o (reg_wr[r]),
                .collision_o (reg_coll[r])
            );

            // Register storage: cleared by either reset, loads the merged lanes on a write.
            always_ff @(posedge aclk or posedge areset) begin
                // NOTE: the file is built from flops rather than a RAM macro because
                // every entry must read zero straight after reset.
                if (areset) begin
                    val_q <= '0;
                end else if (srst) begin
                    val_q <= '0;
                end else if (reg_wr[r]) begin
                    val_q <= mrg_val[r];
                end
            end

            assign reg_val[r] = val_q;
        end
    end

    // With bypass, a write retiring a register this cycle already hides its pending bit.
    assign busy_now = (BYPASS != 0) ? (sb_q & ~reg_wr) : sb_q;

    // Read ports: out-of-range addresses match no register and read zero, not busy.
    always_comb begin
        rd_val  = '0;
        rd_busy = '0;
        for (int i = 0; i < NRD; i++) begin
            for (int r = 0; r < NREG; r++) begin
                if (rd_addr[i*REG_ADDRW +: REG_ADDRW] == REG_ADDRW'(r)) begin
                    rd_val[i*XLEN +: XLEN] = (BYPASS != 0) ? mrg_val[r] : reg_val[r];
                    rd_busy[i]             = busy_now[r];
                end
            end
        end
    end

    // Issue handshake: x0 and out-of-range targets are always accepted and reserve nothing.
    always_comb begin
        iss_ready = 1'b1;
        sb_set    = '0;
        for (int r = 0; r < NREG; r++) begin
            if (iss_addr == REG_ADDRW'(r)) begin
                iss_ready = ~busy_now[r];
            end
        end
        for (int r = 1; r < NREG; r++) begin
            sb_set[r] = iss_valid & iss_ready & (iss_addr == REG_ADDRW'(r));
        end
    end

    // A retiring write and a new reservation on the same register leave it pending.
    assign sb_d = (sb_q & ~reg_wr) | sb_set;

    // Address error: any read port, enabled write port or issue outside the file.
    always_comb begin
        err_d = iss_valid & ~addr_in_range(iss_addr, NREG);
        for (int i = 0; i < NRD; i++) begin
            err_d = err_d | ~addr_in_range(rd_addr[i*REG_ADDRW +: REG_ADDRW], NREG);
        end
        for (int p = 0; p < NWR; p++) begin
            err_d = err_d | (wr_en[p] & ~addr_in_range(wr_addr[p*REG_ADDRW +: REG_ADDRW], NREG));
        end
    end

    // Scoreboard, pending count and one-cycle status pulses.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            sb_q   <= '0;
            cnt_q  <= '0;
            coll_q <= 1'b0;
            err_q  <= 1'b0;
        end else if (srst) begin
            sb_q   <= '0;
            cnt_q  <= '0;
            coll_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            sb_q   <= sb_d;
            cnt_q  <= popcount(RV32I_NREG'(sb_q));
            coll_q <= |reg_coll;
            err_q  <= err_d;
        end
    end

    assign pending_cnt  = cnt_q;
    assign wr_collision = coll_q;
    assign addr_err     = err_q;

endmodule

// File: tb/tb_friscv_regfile_sb.sv
// Bench for friscv_regfile_sb: four configurations share one stimulus stream and
// are compared every cycle against an array-based model of the register file.
module tb_friscv_regfile_sb;

    localparam int NINST       = 4;
    localparam int NREG_C [NINST] = '{32, 16, 16, 32};
    localparam int NWR_C  [NINST] = '{3, 2, 4, 1};
    localparam int BYP_C  [NINST] = '{1, 0, 1, 0};
    localparam int RAND_CYCLES = 3000;

    logic         clk = 1'b0;
    logic         areset, srst;
    logic [19:0]  rd_addr;
    logic [3:0]   wr_en;
    logic [19:0]  wr_addr;
    logic [127:0] wr_val;
    logic [15:0]  wr_strb;
    logic         iss_valid;
    logic [4:0]   iss_addr;

    logic [127:0] rd_val_w  [NINST];
    logic [3:0]   rd_busy_w [NINST];
    logic         iss_ready_w [NINST];
    logic [5:0]   cnt_w  [NINST];
    logic         coll_w [NINST];
    logic         err_w  [NINST];

    always #5 clk = ~clk;

    for (genvar k = 0; k < NINST; k++) begin : g_dut
        friscv_regfile_sb #(
            .XLEN   (32),
            .NREG   (NREG_C[k]),
            .NRD    (4),
            .NWR    (NWR_C[k]),
            .BYPASS (BYP_C[k])
        ) u_dut (
            .aclk         (clk),
            .areset       (areset),
            .srst         (srst),
            .rd_addr      (rd_addr),
            .rd_val       (rd_val_w[k]),
            .rd_busy      (rd_busy_w[k]),
            .wr_en        (wr_en[NWR_C[k]-1:0]),
            .wr_addr      (wr_addr[NWR_C[k]*5-1:0]),
            .wr_val       (wr_val[NWR_C[k]*32-1:0]),
            .wr_strb      (wr_strb[NWR_C[k]*4-1:0]),
            .iss_valid    (iss_valid),
            .iss_addr     (iss_addr),
            .iss_ready    (iss_ready_w[k]),
            .pending_cnt  (cnt_w[k]),
            .wr_collision (coll_w[k]),
            .addr_err     (err_w[k])
        );
    end

    // Reference state per configuration.
    logic [31:0] m_mem  [NINST][32];
    logic        m_sb   [NINST][32];
    logic [5:0]  m_cnt  [NINST];
    logic        m_coll [NINST];
    logic        m_err  [NINST];

    int n_vec    = 0;
    int n_miscmp = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miscmp++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int wa(input int p);
        return int'(wr_addr[p*5 +: 5]);
    endfunction

    function automatic logic port_hits(input int k, input int p, input int a);
        return (p < NWR_C[k]) && wr_en[p] && (wa(p) == a);
    endfunction

    function automatic logic written(input int k, input int a);
        for (int p = 0; p < 4; p++) begin
            if (port_hits(k, p, a)) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [31:0] merged(input int k, input int a);
        logic [31:0] v;
        v = m_mem[k][a];
        for (int p = 0; p < 4; p++) begin
            for (int l = 0; l < 4; l++) begin
                if (port_hits(k, p, a) && wr_strb[p*4 + l]) v[l*8 +: 8] = wr_val[p*32 + l*8 +: 8];
            end
        end
        return v;
    endfunction

    function automatic logic [31:0] exp_rd(input int k, input int a);
        if (a == 0 || a >= NREG_C[k]) return 32'h0;
        return (BYP_C[k] != 0) ? merged(k, a) : m_mem[k][a];
    endfunction

    function automatic logic busy(input int k, input int a);
        if (a == 0 || a >= NREG_C[k]) return 1'b0;
        return m_sb[k][a] && !((BYP_C[k] != 0) && written(k, a));
    endfunction

    function automatic logic collision(input int k);
        for (int a = 1; a < NREG_C[k]; a++) begin
            for (int l = 0; l < 4; l++) begin
                int n;
                n = 0;
                for (int p = 0; p < 4; p++) begin
                    if (port_hits(k, p, a) && wr_strb[p*4 + l]) n++;
                end
                if (n >= 2) return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    function automatic logic bad_addr(input int k);
        logic e;
        e = iss_valid && (int'(iss_addr) >= NREG_C[k]);
        for (int i = 0; i < 4; i++) begin
            if (int'(rd_addr[i*5 +: 5]) >= NREG_C[k]) e = 1'b1;
        end
        for (int p = 0; p < NWR_C[k]; p++) begin
            if (wr_en[p] && wa(p) >= NREG_C[k]) e = 1'b1;
        end
        return e;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NINST; k++) begin
            for (int a = 0; a < 32; a++) begin
                m_mem[k][a] = 32'h0;
                m_sb[k][a]  = 1'b0;
            end
            m_cnt[k]  = 6'd0;
            m_coll[k] = 1'b0;
            m_err[k]  = 1'b0;
        end
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_step();
        logic ready;
        int   pc;
        int   ia;
        if (areset || srst) begin
            model_reset();
        end else begin
            ia = int'(iss_addr);
            for (int k = 0; k < NINST; k++) begin
                ready = !busy(k, ia);
                pc = 0;
                for (int a = 0; a < 32; a++) pc += int'(m_sb[k][a]);
                m_cnt[k]  = 6'(pc);
                m_coll[k] = collision(k);
                m_err[k]  = bad_addr(k);
                for (int a = 1; a < NREG_C[k]; a++) begin
                    if (written(k, a)) begin
                        m_mem[k][a] = merged(k, a);
                        m_sb[k][a]  = 1'b0;
                    end
                end
                if (iss_valid && ready && ia != 0 && ia < NREG_C[k]) m_sb[k][ia] = 1'b1;
            end
        end
    endtask

    task automatic compare_all();
        int a;
        for (int k = 0; k < NINST; k++) begin
            for (int i = 0; i < 4; i++) begin
                a = int'(rd_addr[i*5 +: 5]);
                check($sformatf("d%0d rd_val%0d x%0d", k, i, a), rd_val_w[k][i*32 +: 32], exp_rd(k, a));
                check($sformatf("d%0d rd_busy%0d x%0d", k, i, a), 32'(rd_busy_w[k][i]), 32'(busy(k, a)));
            end
            check($sformatf("d%0d iss_ready x%0d", k, iss_addr), 32'(iss_ready_w[k]), 32'(!busy(k, int'(iss_addr))));
            check($sformatf("d%0d pending_cnt", k), 32'(cnt_w[k]), 32'(m_cnt[k]));
            check($sformatf("d%0d wr_collision", k), 32'(coll_w[k]), 32'(m_coll[k]));
            check($sformatf("d%0d addr_err", k), 32'(err_w[k]), 32'(m_err[k]));
        end
    endtask

    // Inputs are set after a falling edge; compare, take the rising edge, return at the next fall.
    task automatic run_cycle();
        #1;
        compare_all();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle();
        wr_en     = '0;
        wr_addr   = '0;
        wr_val    = '0;
        wr_strb   = '0;
        rd_addr   = '0;
        iss_valid = 1'b0;
        iss_addr  = '0;
        srst      = 1'b0;
    endtask

    task automatic set_wr(input int p, input logic [4:0] a, input logic [31:0] v, input logic [3:0] s);
        wr_en[p]          = 1'b1;
        wr_addr[p*5 +: 5] = a;
        wr_val[p*32 +: 32] = v;
        wr_strb[p*4 +: 4] = s;
    endtask

    function automatic logic [4:0] rnd_addr();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 7));
    endfunction

    initial begin
        areset = 1'b1;
        idle();
        model_reset();
        @(negedge clk);
        #1;
        check("reset pending_cnt", 32'(cnt_w[0]), 32'h0);
        check("reset wr_collision", 32'(coll_w[0]), 32'h0);
        check("reset iss_ready", 32'(iss_ready_w[0]), 32'h1);
        areset = 1'b0;
        run_cycle();

        // Asynchronous reset in the middle of a cycle.
        set_wr(0, 5'd5, 32'hDEADBEEF, 4'hF);
        iss_valid = 1'b1;
        iss_addr  = 5'd6;
        run_cycle();
        idle();
        rd_addr[4:0] = 5'd5;
        run_cycle();
        #1;
        check("t1 x5 before reset", rd_val_w[0][31:0], 32'hDEADBEEF);
        check("t1 cnt before reset", 32'(cnt_w[0]), 32'h1);
        areset = 1'b1;
        model_reset();
        #1;
        check("t1 x5 after reset", rd_val_w[0][31:0], 32'h0);
        check("t1 cnt after reset", 32'(cnt_w[0]), 32'h0);
        areset = 1'b0;
        run_cycle();

        // Byte strobes merge into the old value.
        idle();
        set_wr(0, 5'd3, 32'h11223344, 4'hF);
        run_cycle();
        idle();
        set_wr(1, 5'd3, 32'hAABBCCDD, 4'h5);
        run_cycle();
        idle();
        rd_addr[4:0] = 5'd3;
        #1;
        check("t2 strobe merge", rd_val_w[0][31:0], 32'h11BB33DD);
        run_cycle();

        // Two ports on the same lane: higher index wins, collision pulses.
        idle();
        set_wr(0, 5'd7, 32'h01, 4'h1);
        set_wr(2, 5'd7, 32'h02, 4'h1);
        run_cycle();
        idle();
        rd_addr[4:0] = 5'd7;
        #1;
        check("t3 lane winner", 32'(rd_val_w[0][7:0]), 32'h02);
        check("t3 wr_collision", 32'(coll_w[0]), 32'h1);
        run_cycle();

        // Bypass versus registered read.
        idle();
        set_wr(0, 5'd9, 32'h12345678, 4'hF);
        run_cycle();
        idle();
        set_wr(1, 5'd9, 32'h55, 4'hF);
        rd_addr[4:0] = 5'd9;
        #1;
        check("t4 bypass same cycle", rd_val_w[0][31:0], 32'h55);
        check("t4 no-bypass old value", rd_val_w[1][31:0], 32'h12345678);
        run_cycle();
        idle();
        rd_addr[4:0] = 5'd9;
        #1;
        check("t4 no-bypass next cycle", rd_val_w[1][31:0], 32'h55);
        run_cycle();

        // Scoreboard reservation, set-over-clear, and retirement.
        idle();
        iss_valid = 1'b1;
        iss_addr  = 5'd4;
        rd_addr[4:0] = 5'd4;
        #1;
        check("t5 iss_ready free", 32'(iss_ready_w[0]), 32'h1);
        run_cycle();
        idle();
        iss_addr     = 5'd4;
        rd_addr[4:0] = 5'd4;
        #1;
        check("t5 rd_busy pending", 32'(rd_busy_w[0][0]), 32'h1);
        check("t5 iss_ready pending", 32'(iss_ready_w[0]), 32'h0);
        run_cycle();
        #1;
        check("t5 pending_cnt one", 32'(cnt_w[0]), 32'h1);
        set_wr(0, 5'd4, 32'hCAFEF00D, 4'hF);
        iss_valid = 1'b1;
        #1;
        check("t5 iss_ready via bypass", 32'(iss_ready_w[0]), 32'h1);
        run_cycle();
        idle();
        iss_addr     = 5'd4;
        rd_addr[4:0] = 5'd4;
        #1;
        check("t5 set wins over clear", 32'(rd_busy_w[0][0]), 32'h1);
        check("t5 data of clearing write", rd_val_w[0][31:0], 32'hCAFEF00D);
        set_wr(1, 5'd4, 32'h0, 4'h0);
        run_cycle();
        idle();
        rd_addr[4:0] = 5'd4;
        run_cycle();
        #1;
        check("t5 pending_cnt zero", 32'(cnt_w[0]), 32'h0);
        check("t5 zero strobe keeps data", rd_val_w[0][31:0], 32'hCAFEF00D);

        // RV32E: x20 does not exist.
        idle();
        set_wr(0, 5'd20, 32'hFFFFFFFF, 4'hF);
        iss_valid    = 1'b1;
        iss_addr     = 5'd20;
        rd_addr[4:0] = 5'd20;
        #1;
        check("t6 rd x20 rv32e", rd_val_w[1][31:0], 32'h0);
        check("t6 iss_ready x20 rv32e", 32'(iss_ready_w[1]), 32'h1);
        run_cycle();
        idle();
        #1;
        check("t6 addr_err pulse", 32'(err_w[1]), 32'h1);
        run_cycle();
        #1;
        check("t6 addr_err clears", 32'(err_w[1]), 32'h0);
        check("t6 pending_cnt rv32e", 32'(cnt_w[1]), 32'h0);

        // Synchronous clear.
        srst = 1'b1;
        run_cycle();
        idle();
        rd_addr[4:0] = 5'd3;
        #1;
        check("srst clears x3", rd_val_w[0][31:0], 32'h0);
        check("srst clears pending_cnt", 32'(cnt_w[0]), 32'h0);
        run_cycle();

        // Random traffic against the model.
        for (int c = 0; c < RAND_CYCLES; c++) begin
            idle();
            for (int p = 0; p < 4; p++) begin
                if ($urandom_range(0, 1) == 1) set_wr(p, rnd_addr(), $urandom(), 4'($urandom_range(0, 15)));
            end
            for (int i = 0; i < 4; i++) rd_addr[i*5 +: 5] = rnd_addr();
            iss_valid = 1'($urandom_range(0, 1));
            iss_addr  = rnd_addr();
            srst      = ($urandom_range(0, 199) == 0);
            run_cycle();
        end

        idle();
        run_cycle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
